// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the memory port arbiter: FSM states, pending-slot IDs and the
// fixed issue order between the write, data-read and instruction-read slots.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWaitR
    } arb_state_e;

    typedef enum logic [1:0] {
        SlotW = 2'd0,
        SlotD = 2'd1,
        SlotI = 2'd2
    } slot_id_e;

    localparam int unsigned NumSlots = 3;

    // Row 0: data read before instruction read; row 1: instruction read first.
    // The write slot always leads so a same-address read observes the new data.
    localparam slot_id_e PrioOrder [2][NumSlots] = '{
        '{SlotW, SlotD, SlotI},
        '{SlotW, SlotI, SlotD}
    };

    function automatic slot_id_e pick_slot(logic [NumSlots-1:0] pend, logic inst_first);
        if (pend[PrioOrder[inst_first][0]]) return PrioOrder[inst_first][0];
        if (pend[PrioOrder[inst_first][1]]) return PrioOrder[inst_first][1];
        return PrioOrder[inst_first][2];
    endfunction

endpackage

// File: rtl/mem_port_arbiter_slot.sv
// One captured request: pending flag, address and (optionally) write data.
// Set and clear never coincide in practice; set wins if they do.
module arb_pending_slot #(
    parameter bit HasData = 1'b0
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        set_i,
    input  logic        clr_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] data_i,
    output logic        pend_o,
    output logic [31:0] addr_o,
    output logic [31:0] data_o
);

    logic        pend_q;
    logic [31:0] addr_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pend_q <= 1'b0;
            addr_q <= '0;
        end else if (set_i) begin
            pend_q <= 1'b1;
            addr_q <= addr_i;
        end else if (clr_i) begin
            pend_q <= 1'b0;
        end
    end

    assign pend_o = pend_q;
    assign addr_o = addr_q;

    if (HasData) begin : g_data
        logic [31:0] data_q;

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                data_q <= '0;
            end else if (set_i) begin
                data_q <= data_i;
            end
        end

        assign data_o = data_q;
    end else begin : g_no_data
        logic unused_data;
        assign unused_data = ^data_i;
        assign data_o      = '0;
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Funnels the core's instruction-read, data-read and data-write channels onto one
// memory port: capture all requests at once, then issue them one at a time.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter bit INST_FIRST = 1'b0
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        INST_RDEN,
    input  logic [31:0] INST_RIADDR,
    output logic [31:0] INST_ROADDR,
    output logic        INST_RVALID,
    output logic [31:0] INST_RDATA,
    input  logic        DATA_RDEN,
    input  logic [31:0] DATA_RIADDR,
    output logic [31:0] DATA_ROADDR,
    output logic        DATA_RVALID,
    output logic [31:0] DATA_RDATA,
    input  logic        DATA_WREN,
    input  logic [31:0] DATA_WADDR,
    input  logic [31:0] DATA_WDATA,
    output logic        MEM_WAIT,
    output logic        MEM_REQ,
    output logic        MEM_WE,
    output logic [31:0] MEM_ADDR,
    output logic [31:0] MEM_WDATA,
    input  logic        MEM_ACK,
    input  logic        MEM_RVALID,
    input  logic [31:0] MEM_RDATA
);

    arb_state_e state_q, state_d;
    logic       busy_q, busy_d;
    slot_id_e   rd_slot_q, rd_slot_d;
    slot_id_e   cur;

    logic [NumSlots-1:0] pend, set_vec, clr_vec, pend_left;
    logic [31:0]         w_addr, w_data, d_addr, i_addr;
    logic [31:0]         unused_d_data, unused_i_data;
    logic                capture, accept, rd_done;

    logic        inst_rvalid_q, data_rvalid_q;
    logic [31:0] inst_roaddr_q, inst_rdata_q, data_roaddr_q, data_rdata_q;

    assign capture = (state_q == StIdle) && !busy_q && (DATA_WREN || DATA_RDEN || INST_RDEN);
    assign accept  = (state_q == StIssue) && MEM_ACK;
    assign rd_done = (state_q == StWaitR) && MEM_RVALID;
    assign cur     = pick_slot(pend, INST_FIRST);

    assign set_vec[SlotW] = capture && DATA_WREN;
    assign set_vec[SlotD] = capture && DATA_RDEN;
    assign set_vec[SlotI] = capture && INST_RDEN;

    assign clr_vec[SlotW] = accept && (cur == SlotW);
    assign clr_vec[SlotD] = rd_done && (rd_slot_q == SlotD);
    assign clr_vec[SlotI] = rd_done && (rd_slot_q == SlotI);

    assign pend_left = pend & ~clr_vec;

    arb_pending_slot #(.HasData(1'b1)) u_slot_w (
        .clk_i  (CLK),
        .rst_i  (RST),
        .set_i  (set_vec[SlotW]),
        .clr_i  (clr_vec[SlotW]),
        .addr_i (DATA_WADDR),
        .data_i (DATA_WDATA),
        .pend_o (pend[SlotW]),
        .addr_o (w_addr),
        .data_o (w_data)
    );

    arb_pending_slot #(.HasData(1'b0)) u_slot_d (
        .clk_i  (CLK),
        .rst_i  (RST),
        .set_i  (set_vec[SlotD]),
        .clr_i  (clr_vec[SlotD]),
        .addr_i (DATA_RIADDR),
        .data_i (32'h0),
        .pend_o (pend[SlotD]),
        .addr_o (d_addr),
        .data_o (unused_d_data)
    );

    arb_pending_slot #(.HasData(1'b0)) u_slot_i (
        .clk_i  (CLK),
        .rst_i  (RST),
        .set_i  (set_vec[SlotI]),
        .clr_i  (clr_vec[SlotI]),
        .addr_i (INST_RIADDR),
        .data_i (32'h0),
        .pend_o (pend[SlotI]),
        .addr_o (i_addr),
        .data_o (unused_i_data)
    );

    always_comb begin
        state_d   = state_q;
        busy_d    = busy_q;
        rd_slot_d = rd_slot_q;
        case (state_q)
            StIdle: begin
                if (capture) begin
                    state_d = StIssue;
                    busy_d  = 1'b1;
                end
            end
            StIssue: begin
                if (MEM_ACK) begin
                    if (cur == SlotW) begin
                        state_d = (|pend_left) ? StIssue : StIdle;
                        busy_d  = |pend_left;
                    end else begin
                        state_d   = StWaitR;
                        rd_slot_d = cur;
                    end
                end
            end
            StWaitR: begin
                if (MEM_RVALID) begin
                    state_d = (|pend_left) ? StIssue : StIdle;
                    busy_d  = |pend_left;
                end
            end
            default: begin
                state_d = StIdle;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q       <= StIdle;
            busy_q        <= 1'b0;
            rd_slot_q     <= SlotW;
            inst_rvalid_q <= 1'b0;
            data_rvalid_q <= 1'b0;
            inst_roaddr_q <= '0;
            inst_rdata_q  <= '0;
            data_roaddr_q <= '0;
            data_rdata_q  <= '0;
        end else begin
            state_q       <= state_d;
            busy_q        <= busy_d;
            rd_slot_q     <= rd_slot_d;
            inst_rvalid_q <= clr_vec[SlotI];
            data_rvalid_q <= clr_vec[SlotD];
            if (clr_vec[SlotI]) begin
                inst_roaddr_q <= i_addr;
                inst_rdata_q  <= MEM_RDATA;
            end
            if (clr_vec[SlotD]) begin
                data_roaddr_q <= d_addr;
                data_rdata_q  <= MEM_RDATA;
            end
        end
    end

    // Request fields follow the selected slot; the pending set cannot change in
    // StIssue, so they stay stable until accepted.
    always_comb begin
        MEM_REQ   = 1'b0;
        MEM_WE    = 1'b0;
        MEM_ADDR  = '0;
        MEM_WDATA = '0;
        if (state_q == StIssue) begin
            MEM_REQ = 1'b1;
            case (cur)
                SlotW: begin
                    MEM_WE    = 1'b1;
                    MEM_ADDR  = w_addr;
                    MEM_WDATA = w_data;
                end
                SlotD:   MEM_ADDR = d_addr;
                default: MEM_ADDR = i_addr;
            endcase
        end
    end

    assign MEM_WAIT    = busy_q;
    assign INST_RVALID = inst_rvalid_q;
    assign INST_ROADDR = inst_roaddr_q;
    assign INST_RDATA  = inst_rdata_q;
    assign DATA_RVALID = data_rvalid_q;
    assign DATA_ROADDR = data_roaddr_q;
    assign DATA_RDATA  = data_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: one instance per issue order, driven cycle by cycle
// against a queue-based model of the capture/issue/response rules.
module tb_mem_port_arbiter;

    typedef struct packed {
        logic        we;
        logic        is_inst;
        logic [31:0] addr;
        logic [31:0] wdata;
    } op_t;

    logic clk, rst;
    logic        inst_rden [2], data_rden [2], data_wren [2], mem_ack [2], mem_rvalid [2];
    logic [31:0] inst_riaddr [2], data_riaddr [2], data_waddr [2], data_wdata [2];
    logic [31:0] mem_rdata [2];
    logic        inst_rvalid [2], data_rvalid [2], mem_wait [2], mem_req [2], mem_we [2];
    logic [31:0] inst_roaddr [2], inst_rdata [2], data_roaddr [2], data_rdata [2];
    logic [31:0] mem_addr [2], mem_wdata [2];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        mem_port_arbiter #(.INST_FIRST(g == 1)) u_dut (
            .CLK         (clk),
            .RST         (rst),
            .INST_RDEN   (inst_rden[g]),
            .INST_RIADDR (inst_riaddr[g]),
            .INST_ROADDR (inst_roaddr[g]),
            .INST_RVALID (inst_rvalid[g]),
            .INST_RDATA  (inst_rdata[g]),
            .DATA_RDEN   (data_rden[g]),
            .DATA_RIADDR (data_riaddr[g]),
            .DATA_ROADDR (data_roaddr[g]),
            .DATA_RVALID (data_rvalid[g]),
            .DATA_RDATA  (data_rdata[g]),
            .DATA_WREN   (data_wren[g]),
            .DATA_WADDR  (data_waddr[g]),
            .DATA_WDATA  (data_wdata[g]),
            .MEM_WAIT    (mem_wait[g]),
            .MEM_REQ     (mem_req[g]),
            .MEM_WE      (mem_we[g]),
            .MEM_ADDR    (mem_addr[g]),
            .MEM_WDATA   (mem_wdata[g]),
            .MEM_ACK     (mem_ack[g]),
            .MEM_RVALID  (mem_rvalid[g]),
            .MEM_RDATA   (mem_rdata[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Model state: ph 0 = nothing outstanding, 1 = request on the port, 2 = read in flight.
    int          n_total = 0, n_pass = 0, n_fail = 0;
    int          ph = 0, hold = 0, lat = 0;
    int          hold_cfg = 0, lat_cfg = 2;
    bit          hold_rand = 0, lat_rand = 0, junk = 0, rst_now = 0, late_rv = 0;
    op_t         q[$];
    op_t         rd_op;
    logic        exp_iv = 1'b0, exp_dv = 1'b0;
    logic [31:0] exp_ira [2], exp_ird [2], exp_dra [2], exp_drd [2];
    logic [31:0] mem [logic [31:0]];
    string       obs_pulses;
    logic        r_wr, r_dr, r_ir;
    logic [31:0] r_wa, r_wd, r_da, r_ia;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_str(input string tag, input string obs, input string exp);
        n_total++;
        assert (obs == exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed '%s' expected '%s'", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : {a[15:0], 16'hA5C3};
    endfunction

    function automatic int next_hold();
        return hold_rand ? int'($urandom_range(0, hold_cfg)) : hold_cfg;
    endfunction

    function automatic int next_lat();
        return lat_rand ? int'($urandom_range(1, lat_cfg)) : lat_cfg;
    endfunction

    task automatic clear_reqs();
        r_wr = 1'b0; r_dr = 1'b0; r_ir = 1'b0;
    endtask

    task automatic rand_reqs();
        r_wr = 1'($urandom_range(0, 1));
        r_dr = 1'($urandom_range(0, 1));
        r_ir = 1'($urandom_range(0, 1));
        r_wa = 32'($urandom_range(0, 7)) << 2;
        r_da = 32'($urandom_range(0, 7)) << 2;
        r_ia = 32'h2000_0000 | (32'($urandom_range(0, 7)) << 2);
        r_wd = $urandom;
    endtask

    task automatic park(input int k);
        inst_rden[k] = 1'b0; data_rden[k] = 1'b0; data_wren[k] = 1'b0;
        mem_ack[k] = 1'b0; mem_rvalid[k] = 1'b0;
    endtask

    // Capture takes every presented request; the issue order is write first, then
    // the two reads in the order selected for that instance.
    task automatic capture(input int k);
        op_t d_op, i_op;
        d_op = '{we: 1'b0, is_inst: 1'b0, addr: r_da, wdata: 32'h0};
        i_op = '{we: 1'b0, is_inst: 1'b1, addr: r_ia, wdata: 32'h0};
        if (r_wr) q.push_back('{we: 1'b1, is_inst: 1'b0, addr: r_wa, wdata: r_wd});
        if (k == 1) begin
            if (r_ir) q.push_back(i_op);
            if (r_dr) q.push_back(d_op);
        end else begin
            if (r_dr) q.push_back(d_op);
            if (r_ir) q.push_back(i_op);
        end
        if (q.size() != 0) begin
            ph   = 1;
            hold = next_hold();
        end
    endtask

    // Observe instance k at the current sample point, drive the next cycle, then
    // advance the model and the clock together.
    task automatic cycle(input int k);
        op_t op;
        check("mem_wait", 32'(mem_wait[k]), 32'(ph != 0));
        check("inst_rvalid", 32'(inst_rvalid[k]), 32'(exp_iv));
        check("inst_roaddr", inst_roaddr[k], exp_ira[k]);
        check("inst_rdata", inst_rdata[k], exp_ird[k]);
        check("data_rvalid", 32'(data_rvalid[k]), 32'(exp_dv));
        check("data_roaddr", data_roaddr[k], exp_dra[k]);
        check("data_rdata", data_rdata[k], exp_drd[k]);
        check("mem_req", 32'(mem_req[k]), 32'(ph == 1));
        if (ph == 1) begin
            check("mem_we", 32'(mem_we[k]), 32'(q[0].we));
            check("mem_addr", mem_addr[k], q[0].addr);
            if (q[0].we) check("mem_wdata", mem_wdata[k], q[0].wdata);
        end
        if (inst_rvalid[k] === 1'b1) obs_pulses = {obs_pulses, "I"};
        if (data_rvalid[k] === 1'b1) obs_pulses = {obs_pulses, "D"};

        rst            = rst_now;
        inst_rden[k]   = r_ir;
        data_rden[k]   = r_dr;
        data_wren[k]   = r_wr;
        inst_riaddr[k] = r_ia;
        data_riaddr[k] = r_da;
        data_waddr[k]  = r_wa;
        data_wdata[k]  = r_wd;
        mem_ack[k]     = junk ? 1'($urandom_range(0, 1)) : 1'b0;
        mem_rvalid[k]  = junk ? 1'($urandom_range(0, 1)) : 1'b0;
        mem_rdata[k]   = $urandom;
        exp_iv = 1'b0;
        exp_dv = 1'b0;
        if (rst_now) begin
            q.delete();
            ph = 0;
            for (int j = 0; j < 2; j++) begin
                exp_ira[j] = '0; exp_ird[j] = '0; exp_dra[j] = '0; exp_drd[j] = '0;
            end
        end else if (ph == 0) begin
            if (late_rv) begin
                mem_rvalid[k] = 1'b1;
                late_rv = 0;
            end
            capture(k);
        end else if (ph == 1) begin
            if (hold > 0) begin
                mem_ack[k] = 1'b0;
                hold--;
            end else begin
                mem_ack[k] = 1'b1;
                op = q.pop_front();
                if (op.we) begin
                    mem[op.addr] = op.wdata;
                    ph   = (q.size() != 0) ? 1 : 0;
                    hold = next_hold();
                end else begin
                    rd_op = op;
                    lat   = next_lat() - 1;
                    ph    = 2;
                end
            end
        end else begin
            if (lat == 0) begin
                mem_rvalid[k] = 1'b1;
                mem_rdata[k]  = mem_rd(rd_op.addr);
                if (rd_op.is_inst) begin
                    exp_iv = 1'b1; exp_ira[k] = rd_op.addr; exp_ird[k] = mem_rdata[k];
                end else begin
                    exp_dv = 1'b1; exp_dra[k] = rd_op.addr; exp_drd[k] = mem_rdata[k];
                end
                ph   = (q.size() != 0) ? 1 : 0;
                hold = next_hold();
            end else begin
                mem_rvalid[k] = 1'b0;
                lat--;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int k, input bit toggle);
        for (int n = 0; n < 200 && ph != 0; n++) begin
            if (toggle) rand_reqs();
            else clear_reqs();
            cycle(k);
        end
        clear_reqs();
        cycle(k);
    endtask

    task automatic check_zero(input int k, input string tag);
        check({tag, "_wait"}, 32'(mem_wait[k]), 32'h0);
        check({tag, "_req"}, 32'(mem_req[k]), 32'h0);
        check({tag, "_we"}, 32'(mem_we[k]), 32'h0);
        check({tag, "_addr"}, mem_addr[k], 32'h0);
        check({tag, "_wdata"}, mem_wdata[k], 32'h0);
        check({tag, "_ivalid"}, 32'(inst_rvalid[k]), 32'h0);
        check({tag, "_iaddr"}, inst_roaddr[k], 32'h0);
        check({tag, "_idata"}, inst_rdata[k], 32'h0);
        check({tag, "_dvalid"}, 32'(data_rvalid[k]), 32'h0);
        check({tag, "_daddr"}, data_roaddr[k], 32'h0);
        check({tag, "_ddata"}, data_rdata[k], 32'h0);
    endtask

    initial begin
        rst = 1'b1;
        clear_reqs();
        r_wa = '0; r_wd = '0; r_da = '0; r_ia = '0;
        for (int j = 0; j < 2; j++) begin
            park(j);
            inst_riaddr[j] = '0; data_riaddr[j] = '0; data_waddr[j] = '0;
            data_wdata[j] = '0; mem_rdata[j] = '0;
            exp_ira[j] = '0; exp_ird[j] = '0; exp_dra[j] = '0; exp_drd[j] = '0;
        end
        repeat (2) @(posedge clk);
        #1;
        check_zero(0, "reset0");
        check_zero(1, "reset1");

        // Single instruction read, 2-cycle memory latency.
        mem[32'h2000_0000] = 32'h0000_0013;
        obs_pulses = "";
        r_ir = 1'b1; r_ia = 32'h2000_0000;
        cycle(0);
        clear_reqs();
        drain(0, 0);
        check_str("inst_only_pulses", obs_pulses, "I");
        check("inst_only_rdata", inst_rdata[0], 32'h0000_0013);

        // All three channels in one cycle, data read before instruction read.
        obs_pulses = "";
        r_wr = 1'b1; r_wa = 32'h100; r_wd = 32'hDEAD_BEEF;
        r_dr = 1'b1; r_da = 32'h100;
        r_ir = 1'b1; r_ia = 32'h2000_0004;
        cycle(0);
        clear_reqs();
        drain(0, 0);
        check_str("all3_pulses", obs_pulses, "DI");
        check("all3_data_rdata", data_rdata[0], 32'hDEAD_BEEF);
        park(0);

        // Same on the instruction-first instance.
        obs_pulses = "";
        r_wr = 1'b1; r_wa = 32'h100; r_wd = 32'hCAFE_F00D;
        r_dr = 1'b1; r_da = 32'h100;
        r_ir = 1'b1; r_ia = 32'h2000_0004;
        cycle(1);
        clear_reqs();
        drain(1, 0);
        check_str("inst_first_pulses", obs_pulses, "ID");
        check("inst_first_data_rdata", data_rdata[1], 32'hCAFE_F00D);
        park(1);

        // Write held off by MEM_ACK for 5 cycles.
        hold_cfg = 5;
        r_wr = 1'b1; r_wa = 32'h40; r_wd = 32'h1234_5678;
        cycle(0);
        clear_reqs();
        drain(0, 0);
        hold_cfg = 0;

        // Reset while a read is in flight, then a late MEM_RVALID.
        obs_pulses = "";
        lat_cfg = 3;
        r_dr = 1'b1; r_da = 32'h100;
        cycle(0);
        clear_reqs();
        for (int n = 0; n < 20 && ph != 2; n++) cycle(0);
        rst_now = 1; late_rv = 1;
        cycle(0);
        rst_now = 0;
        cycle(0);
        check_zero(0, "post_reset");
        r_ir = 1'b1; r_ia = 32'h2000_0000;
        cycle(0);
        clear_reqs();
        drain(0, 0);
        check_str("post_reset_pulses", obs_pulses, "I");

        // Requests toggling while stalled, then spurious downstream strobes when idle.
        junk = 1;
        r_wr = 1'b1; r_wa = 32'h8; r_wd = 32'h0BAD_F00D;
        r_dr = 1'b1; r_da = 32'h8;
        cycle(0);
        drain(0, 1);
        repeat (6) cycle(0);
        park(0);

        // Randomised traffic on both instances.
        hold_rand = 1; hold_cfg = 3; lat_rand = 1; lat_cfg = 3;
        for (int k = 0; k < 2; k++) begin
            for (int n = 0; n < 300; n++) begin
                if (ph != 0 || $urandom_range(0, 2) == 0) rand_reqs();
                else clear_reqs();
                cycle(k);
            end
            drain(k, 0);
            park(k);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
